// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch queue: default widths and depth, the queue
// entry layout and the pointer-width helper.
package fetch_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int INSN_W_DEF = 32;
  localparam int DEPTH_DEF  = 8;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [INSN_W_DEF-1:0] instr;
  } fq_entry_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fetch_queue_chk.sv
// Protocol checker for the fetch queue input side: slot1 may never be fetched
// without slot0.
module fetch_queue_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [1:0] in_valid
);

  ap_no_lone_slot1: assert property (@(posedge clk) disable iff (!rst_n)
                                     in_valid != 2'b10);

endmodule

// File: rtl/fq_storage.sv
// Register-based entry storage with two write ports and two combinational read
// ports. Contents are deliberately not reset; validity is tracked by the owner.
module fq_storage
  import fetch_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INSN_W = INSN_W_DEF
) (
  input  logic                      clk,
  input  logic                      we0,
  input  logic                      we1,
  input  logic [ptr_w(DEPTH)-1:0]   waddr0,
  input  logic [ptr_w(DEPTH)-1:0]   waddr1,
  input  logic [ADDR_W-1:0]         wpc0,
  input  logic [ADDR_W-1:0]         wpc1,
  input  logic [INSN_W-1:0]         winstr0,
  input  logic [INSN_W-1:0]         winstr1,
  input  logic [ptr_w(DEPTH)-1:0]   raddr0,
  input  logic [ptr_w(DEPTH)-1:0]   raddr1,
  output logic [ADDR_W-1:0]         rpc0,
  output logic [ADDR_W-1:0]         rpc1,
  output logic [INSN_W-1:0]         rinstr0,
  output logic [INSN_W-1:0]         rinstr1
);

  logic [ADDR_W-1:0] pc_mem_r    [DEPTH];
  logic [INSN_W-1:0] instr_mem_r [DEPTH];

  // Write ports; the two addresses are always distinct (tail and tail+1).
  always_ff @(posedge clk) begin
    if (we0) begin
      pc_mem_r[waddr0]    <= wpc0;
      instr_mem_r[waddr0] <= winstr0;
    end
    if (we1) begin
      pc_mem_r[waddr1]    <= wpc1;
      instr_mem_r[waddr1] <= winstr1;
    end
  end

  assign rpc0    = pc_mem_r[raddr0];
  assign rpc1    = pc_mem_r[raddr1];
  assign rinstr0 = instr_mem_r[raddr0];
  assign rinstr1 = instr_mem_r[raddr1];

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue instruction fetch queue: up to two pushes and two pops per cycle,
// flush redirect, program-order delivery of head and head+1 to decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INSN_W = INSN_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              in_valid,
  input  logic [ADDR_W-1:0]       in_pc,
  input  logic [INSN_W-1:0]       in_instr0,
  input  logic [INSN_W-1:0]       in_instr1,
  output logic                    in_ready,
  output logic [1:0]              out_valid,
  output logic [ADDR_W-1:0]       out_pc0,
  output logic [ADDR_W-1:0]       out_pc1,
  output logic [INSN_W-1:0]       out_instr0,
  output logic [INSN_W-1:0]       out_instr1,
  input  logic [1:0]              out_take,
  input  logic                    flush,
  output logic [ptr_w(DEPTH):0]   count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C   = CW'(32'd1);
  localparam logic [CW-1:0] TWO_C   = CW'(32'd2);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(32'd1);

  logic [PW-1:0]     head_r, tail_r, head_nxt_s, tail_nxt_s, head_p1_s, tail_p1_s;
  logic [CW-1:0]     count_r, count_nxt_s, push_n_s, pop_n_s, take_req_s;
  logic              in_ready_r, in_ready_nxt_s;
  logic [1:0]        out_valid_r, out_valid_nxt_s;
  logic              we0_s, we1_s;
  logic [ADDR_W-1:0] rpc0_s, rpc1_s;
  logic [INSN_W-1:0] rinstr0_s, rinstr1_s;

  assign head_p1_s = head_r + PTR_ONE;
  assign tail_p1_s = tail_r + PTR_ONE;

  // Push/pop amounts, pointer and occupancy next state; flush overrides all.
  always_comb begin
    push_n_s        = ZERO_C;
    take_req_s      = ZERO_C;
    pop_n_s         = ZERO_C;
    head_nxt_s      = head_r;
    tail_nxt_s      = tail_r;
    count_nxt_s     = count_r;
    we0_s           = 1'b0;
    we1_s           = 1'b0;
    in_ready_nxt_s  = 1'b1;
    out_valid_nxt_s = 2'b00;

    if (in_ready_r) begin
      case (in_valid)
        2'b01:   push_n_s = ONE_C;
        2'b11:   push_n_s = TWO_C;
        default: push_n_s = ZERO_C;
      endcase
    end else begin
      push_n_s = ZERO_C;
    end

    // out_take of 3 is clamped to 2, then to the current occupancy
    case (out_take)
      2'b00:   take_req_s = ZERO_C;
      2'b01:   take_req_s = ONE_C;
      default: take_req_s = TWO_C;
    endcase
    pop_n_s = (take_req_s > count_r) ? count_r : take_req_s;

    if (flush) begin
      head_nxt_s  = {PW{1'b0}};
      tail_nxt_s  = {PW{1'b0}};
      count_nxt_s = ZERO_C;
      we0_s       = 1'b0;
      we1_s       = 1'b0;
    end else begin
      head_nxt_s  = head_r + pop_n_s[PW-1:0];
      tail_nxt_s  = tail_r + push_n_s[PW-1:0];
      count_nxt_s = count_r + push_n_s - pop_n_s;
      we0_s       = (push_n_s != ZERO_C);
      we1_s       = (push_n_s == TWO_C);
    end

    in_ready_nxt_s = ((DEPTH_C - count_nxt_s) >= TWO_C);
    if (count_nxt_s == ZERO_C) begin
      out_valid_nxt_s = 2'b00;
    end else if (count_nxt_s == ONE_C) begin
      out_valid_nxt_s = 2'b01;
    end else begin
      out_valid_nxt_s = 2'b11;
    end
  end

  // Pointer, occupancy and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r      <= {PW{1'b0}};
      tail_r      <= {PW{1'b0}};
      count_r     <= ZERO_C;
      in_ready_r  <= 1'b1;
      out_valid_r <= 2'b00;
    end else begin
      head_r      <= head_nxt_s;
      tail_r      <= tail_nxt_s;
      count_r     <= count_nxt_s;
      in_ready_r  <= in_ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

  fq_storage #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .INSN_W (INSN_W)
  ) u_storage (
    .clk     (clk),
    .we0     (we0_s),
    .we1     (we1_s),
    .waddr0  (tail_r),
    .waddr1  (tail_p1_s),
    .wpc0    (in_pc),
    .wpc1    (in_pc + ADDR_W'(32'd4)),
    .winstr0 (in_instr0),
    .winstr1 (in_instr1),
    .raddr0  (head_r),
    .raddr1  (head_p1_s),
    .rpc0    (rpc0_s),
    .rpc1    (rpc1_s),
    .rinstr0 (rinstr0_s),
    .rinstr1 (rinstr1_s)
  );

  fetch_queue_chk u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid)
  );

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign count      = count_r;
  assign out_pc0    = out_valid_r[0] ? rpc0_s    : {ADDR_W{1'b0}};
  assign out_instr0 = out_valid_r[0] ? rinstr0_s : {INSN_W{1'b0}};
  assign out_pc1    = out_valid_r[1] ? rpc1_s    : {ADDR_W{1'b0}};
  assign out_instr1 = out_valid_r[1] ? rinstr1_s : {INSN_W{1'b0}};

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus queues each cycle's transaction,
// a negedge monitor compares the DUT against an in-order entry list and applies it.
module tb_fetch_queue;
  import fetch_pkg::*;

  typedef struct {
    logic [1:0]  v;
    logic [63:0] pc;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [1:0]  take;
    logic        fl;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  in_valid = 2'b00;
  logic [63:0] in_pc = 64'd0;
  logic [31:0] in_instr0 = 32'd0, in_instr1 = 32'd0;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [63:0] out_pc0, out_pc1;
  logic [31:0] out_instr0, out_instr1;
  logic [1:0]  out_take = 2'b00;
  logic        flush = 1'b0;
  logic [3:0]  count;

  int errors = 0;
  int checks = 0;
  txn_t      txn_q[$];
  fq_entry_t exp_q[$];

  fetch_queue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pc(in_pc),
    .in_instr0(in_instr0), .in_instr1(in_instr1), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc0(out_pc0), .out_pc1(out_pc1),
    .out_instr0(out_instr0), .out_instr1(out_instr1), .out_take(out_take),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, record it for the monitor, return #1 after the edge.
  task automatic drive(input logic [1:0] v, input logic [63:0] pc,
                       input logic [1:0] take, input logic fl);
    txn_t t;
    t.v = v; t.pc = pc; t.i0 = $urandom; t.i1 = $urandom; t.take = take; t.fl = fl;
    in_valid = v; in_pc = pc; in_instr0 = t.i0; in_instr1 = t.i1;
    out_take = take; flush = fl;
    txn_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare against the reference entry list, then apply the queued transaction.
  initial begin
    int sz;
    int pops;
    int tk;
    logic rdy;
    logic [1:0] ov;
    txn_t t;
    fq_entry_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        txn_q.delete();
      end else begin
        sz  = exp_q.size();
        rdy = ((8 - sz) >= 2);
        ov  = (sz == 0) ? 2'b00 : ((sz == 1) ? 2'b01 : 2'b11);
        chk("mon_count", 64'(count), 64'(sz));
        chk("mon_in_ready", 64'(in_ready), 64'(rdy));
        chk("mon_out_valid", 64'(out_valid), 64'(ov));
        chk("mon_pc0", out_pc0, (sz >= 1) ? exp_q[0].pc : 64'd0);
        chk("mon_instr0", 64'(out_instr0), (sz >= 1) ? 64'(exp_q[0].instr) : 64'd0);
        chk("mon_pc1", out_pc1, (sz >= 2) ? exp_q[1].pc : 64'd0);
        chk("mon_instr1", 64'(out_instr1), (sz >= 2) ? 64'(exp_q[1].instr) : 64'd0);
        if (txn_q.size() == 0) begin
          errors++;
          $display("FAIL txn_missing: no stimulus recorded for cycle at t=%0t", $time);
        end else begin
          t = txn_q.pop_front();
          if (t.fl) begin
            exp_q.delete();
          end else begin
            tk   = (t.take > 2'd2) ? 2 : int'(t.take);
            pops = (tk < sz) ? tk : sz;
            repeat (pops) void'(exp_q.pop_front());
            if (rdy && t.v[0]) begin
              e.pc = t.pc; e.instr = t.i0;
              exp_q.push_back(e);
              if (t.v[1]) begin
                e.pc = t.pc + 64'd4; e.instr = t.i1;
                exp_q.push_back(e);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] rpc;
    int r;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_pc0", out_pc0, 64'd0);
    chk("rst_instr1", 64'(out_instr1), 64'd0);
    rst_n = 1'b1;

    // First push right after reset release
    drive(2'b11, 64'h100, 2'd0, 1'b0);
    chk("first_count", 64'(count), 64'd2);
    chk("first_out_valid", 64'(out_valid), 64'd3);
    chk("first_pc0", out_pc0, 64'h100);
    chk("first_pc1", out_pc1, 64'h104);

    // Fill to full, then overflow push is dropped
    drive(2'b00, 64'd0, 2'd0, 1'b1);
    for (int k = 0; k < 4; k++) drive(2'b11, 64'h1000 + 64'(8 * k), 2'd0, 1'b0);
    chk("full_count", 64'(count), 64'd8);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    drive(2'b11, 64'h2000, 2'd0, 1'b0);
    chk("drop_count", 64'(count), 64'd8);
    chk("drop_head", out_pc0, 64'h1000);

    // Near-full push gating independent of out_take
    drive(2'b00, 64'd0, 2'd1, 1'b0);
    chk("c7_count", 64'(count), 64'd7);
    chk("c7_in_ready", 64'(in_ready), 64'd0);
    drive(2'b11, 64'h3000, 2'd2, 1'b0);
    chk("c7_drop_count", 64'(count), 64'd5);
    drive(2'b11, 64'h4000, 2'd1, 1'b0);
    chk("c5_count", 64'(count), 64'd6);
    drive(2'b11, 64'h5000, 2'd1, 1'b0);
    chk("c6_count", 64'(count), 64'd7);

    // Wrap-around streaming
    drive(2'b00, 64'd0, 2'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      drive(2'b11, 64'(8 * i), 2'd2, 1'b0);
      chk("wrap_pc0", out_pc0, 64'(8 * i));
    end

    // Flush beats simultaneous push and pop
    drive(2'b00, 64'd0, 2'd0, 1'b1);
    drive(2'b11, 64'h600, 2'd0, 1'b0);
    drive(2'b11, 64'h608, 2'd0, 1'b0);
    drive(2'b01, 64'h610, 2'd0, 1'b0);
    chk("c5_pre_flush", 64'(count), 64'd5);
    drive(2'b11, 64'h700, 2'd2, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 2);
      rpc = {$urandom, $urandom};
      rpc[1:0] = 2'b00;
      drive((r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b11), rpc,
            2'($urandom_range(0, 3)), ($urandom_range(0, 29) == 0));
    end

    // Asynchronous reset mid-stream
    drive(2'b00, 64'd0, 2'd0, 1'b1);
    drive(2'b11, 64'h800, 2'd0, 1'b0);
    drive(2'b01, 64'h808, 2'd0, 1'b0);
    chk("c3_count", 64'(count), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_pc0", out_pc0, 64'd0);
    chk("arst_instr0", 64'(out_instr0), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(2'b11, 64'h200, 2'd0, 1'b0);
    chk("post_rst_pc0", out_pc0, 64'h200);
    chk("post_rst_count", 64'(count), 64'd2);
    drive(2'b00, 64'd0, 2'd2, 1'b0);
    drive(2'b00, 64'd0, 2'd0, 1'b0);
    chk("final_count", 64'(count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 8, entry count; power of two, 4..16.
REQ-002 Parameter ADDR_W, default 64, PC width.
REQ-003 Parameter INSN_W, default 32, instruction width.
REQ-004 CLOCK  in  1  single clock; all state updates on the rising edge.
REQ-005 RESET  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  2  bit0 = slot0 fetched, bit1 = slot1 fetched; 2'b10 is illegal.
REQ-007 in_pc  in  ADDR_W  PC of slot0; slot1 PC = in_pc + 4.
REQ-008 in_instr0 / in_instr1  in  INSN_W each  instruction words from IC, slot0 and slot1.
REQ-009 in_ready  out  1  high when at least 2 entries are free.
REQ-010 out_valid  out  2  bit0 = head entry valid, bit1 = head+1 entry valid.
REQ-011 out_pc0 / out_pc1  out  ADDR_W each  PCs of head and head+1.
REQ-012 out_instr0 / out_instr1  out  INSN_W each  instructions of head and head+1.
REQ-013 out_take  in  2  number of entries decode consumes this cycle: 0, 1 or 2.
REQ-014 flush  in  1  branch redirect; discards all entries.
REQ-015 count  out  log2(DEPTH)+1  current occupancy.

Function
REQ-016 Push SHALL occur only when in_ready=1; push count = popcount(in_valid); pushes with in_ready=0 are dropped.
REQ-017 Slot0 SHALL be written at the tail, slot1 at tail+1; tail advances by push count modulo DEPTH.
REQ-018 Pop count SHALL be min(out_take, occupancy); an excess out_take is clamped, never underflows.
REQ-019 Head SHALL advance by pop count modulo DEPTH; wrap-around needs no extra cycle.
REQ-020 Simultaneous push and pop SHALL update count as count + pushes - pops in one cycle.
REQ-021 in_ready SHALL depend on registered count only (DEPTH - count >= 2), not on out_take.
REQ-022 An entry pushed at edge N SHALL first appear on the outputs after edge N; there is no empty-queue bypass.
REQ-023 out_valid SHALL be 2'b00 when count=0, 2'b01 when count=1, and 2'b11 when count>=2.
REQ-024 out_pc/out_instr for an invalid slot SHALL be driven to zero.
REQ-025 flush SHALL take priority over push and pop: on the next edge head=tail=0, count=0, and same-cycle pushes are discarded.
REQ-026 in_valid=2'b10 SHALL be treated as no push; a simulation assertion SHALL flag it.
REQ-027 The queue SHALL preserve program order: outputs follow push order exactly.

Reset
REQ-028 RESET low SHALL asynchronously clear head, tail and count to 0.
REQ-029 During reset, outputs SHALL be out_valid=0, out_pc*=0, out_instr*=0, count=0 and in_ready=1.
REQ-030 Reset mid-operation SHALL discard all entries; storage contents need not be cleared.
REQ-031 Reset release SHALL be synchronous-safe: the first push is accepted on the first edge after deassertion.

Structure
REQ-032 Shared package fetch_pkg SHALL hold ADDR_W, INSN_W, DEPTH defaults, the entry struct {pc, instr} and the pointer-width function.
REQ-033 Storage SHALL be a sub-module fq_storage with 2 write ports and 2 read ports, unreset and register based.
REQ-034 Pointer, count and flush control SHALL live in fetch_queue.

Verification
REQ-035 Reset, then push in_pc=0x100 with two instructions, out_take=0 -> after the edge count=2, out_valid=2'b11, out_pc0=0x100, out_pc1=0x104.
REQ-036 Fill with 4 dual pushes (DEPTH=8) -> count=8 and in_ready=0; a further push is dropped and count stays 8.
REQ-037 count=7, push 2 with out_take=2 -> in_ready=0 beforehand, push dropped, count=5; at count=6 a push of 2 with out_take=1 -> count=7.
REQ-038 Wrap-around: 20 cycles of push 2 / take 2 starting at in_pc=0x0 -> out_pc0 sequence 0x0, 0x8, 0x10, ... with no gaps or reorders.
REQ-039 count=5, flush=1 together with push 2 and out_take=2 -> after the edge count=0, out_valid=0, in_ready=1.
REQ-040 Assert RESET low mid-stream at count=3 -> outputs zero immediately without a clock edge; after release a push of in_pc=0x200 appears as head.
